// File: rtl/sync_cnt_pkg.sv
// Shared definitions for the synchronous JK-based counters: direction
// encoding and the per-bit excitation modes used by the next-state logic.
package sync_cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // How the JK inputs of every bit are driven on the coming edge.
  typedef enum logic [1:0] {
    EXC_HOLD  = 2'b00,  // J = K = 0, keep the count
    EXC_STEP  = 2'b01,  // J = K = toggle, plain binary +/-1
    EXC_FORCE = 2'b10   // J = n, K = ~n, jam a target value (wrap/load)
  } exc_mode_e;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset to 0.
// JK = 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update, reset has priority over the excitation inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sync_updown_jk.sv
// Synchronous modulo-MOD up/down counter built from one JK flip-flop per bit.
// Priority per edge: reset > load > en > hold. tc flags that the next
// enabled step wraps; wrap is a registered one-cycle pulse after a wrap.
module sync_updown_jk
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic             in_range;
  logic             at_end;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  exc_mode_e        mode;

  // Compared in 32 bits so the check stays meaningful when MOD == 2**WIDTH.
  assign in_range = (32'(q) < MOD);
  assign load_val = (32'(d) >= MOD) ? LAST : d;

  // Terminal-count detection: the current value is the last one in the
  // selected direction; an out-of-range state never reports terminal count.
  always_comb begin
    at_end = 1'b0;
    if (up_dn == DIR_UP) begin
      at_end = in_range & (q == LAST);
    end else begin
      at_end = in_range & (q == {WIDTH{1'b0}});
    end
  end

  assign tc = ~reset & en & ~load & at_end;

  // Binary toggle enables: bit i flips when all lower bits are 1 (up)
  // or all lower bits are 0 (down); bit 0 always flips.
  always_comb begin
    logic [WIDTH-1:0] mask;
    toggle = {WIDTH{1'b0}};
    mask   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (up_dn == DIR_UP) begin
        toggle[i] = ((q & mask) == mask);
      end else begin
        toggle[i] = ((q & mask) == {WIDTH{1'b0}});
      end
      mask[i] = 1'b1;
    end
  end

  // Select how the flip-flops are excited and, for forced moves, the target.
  always_comb begin
    mode   = EXC_HOLD;
    target = q;
    if (load) begin
      mode   = EXC_FORCE;
      target = load_val;
    end else if (en) begin
      if (!in_range) begin
        mode   = EXC_FORCE;
        target = {WIDTH{1'b0}};
      end else if (at_end) begin
        mode   = EXC_FORCE;
        target = (up_dn == DIR_UP) ? {WIDTH{1'b0}} : LAST;
      end else begin
        mode   = EXC_STEP;
        target = q;
      end
    end else begin
      mode   = EXC_HOLD;
      target = q;
    end
  end

  // Translate the selected mode into per-bit J/K excitation.
  always_comb begin
    j = {WIDTH{1'b0}};
    k = {WIDTH{1'b0}};
    case (mode)
      EXC_HOLD: begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
      end
      EXC_STEP: begin
        j = toggle;
        k = toggle;
      end
      EXC_FORCE: begin
        j = target;
        k = ~target;
      end
      default: begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff u_ff (
        .clk   (clk),
        .reset (reset),
        .j     (j[gi]),
        .k     (k[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  // One-cycle pulse following every wrap step.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule
